reg_bank_seq: RTL and testbench
===============================

// Module: reg_bank_seq
// PURPOSE
//  Initiator for the reg_bank read/write interface: accepts one ALU-style command per
//  valid/ready handshake and sequences it against reg_bank.
//  Each command reads rs1/rs2 via fnt1/fnt2, computes the result, and writes it back via
//  e_l/reg_e/dado. Sits between the instruction/test driver and reg_bank.
// PARAMETERS
//  DATA_W  32  data width; matches reg_bank dado/dado_l_* width
//  ADDR_W  2   register select width; matches reg_bank fnt1/fnt2/reg_e
// PORTS
//  clk       in   1       rising-edge clock; same clock as reg_bank
//  rst_n     in   1       asynchronous, active-low reset
//  cmd_valid in   1       command present
//  cmd_ready out  1       command accepted on edge where cmd_valid&&cmd_ready
//  cmd_op    in   2       00 ADD, 01 SUB, 10 AND, 11 MOVI (rd <= imm)
//  cmd_rd    in   ADDR_W  destination register
//  cmd_rs1   in   ADDR_W  source register 1 (ignored for MOVI)
//  cmd_rs2   in   ADDR_W  source register 2 (ignored for MOVI)
//  cmd_imm   in   DATA_W  immediate (MOVI only)
//  e_l       out  1       reg_bank write enable
//  reg_e     out  ADDR_W  reg_bank write select
//  dado      out  DATA_W  reg_bank write data
//  fnt1      out  ADDR_W  reg_bank read select 1
//  fnt2      out  ADDR_W  reg_bank read select 2
//  dado_l_1  in   DATA_W  reg_bank read data 1 (combinational from fnt1)
//  dado_l_2  in   DATA_W  reg_bank read data 2 (combinational from fnt2)
//  result    out  DATA_W  last written value
//  zero      out  1       result == 0
//  done      out  1       one-cycle pulse: command retired
//  busy      out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE. All outputs and latched fields = 0: e_l, reg_e,
//    dado, fnt1, fnt2, result, zero, done. cmd_ready is forced 0 while rst_n=0.
//  - FSM states and transitions:
//      IDLE -> READ on accept of ADD/SUB/AND.
//      IDLE -> WRITE on accept of MOVI.
//      READ -> EXEC -> WRITE -> IDLE, unconditionally.
//  - cmd_ready = (state==IDLE) && rst_n. cmd_* are latched on accept; later changes are
//    ignored until the next accept.
//  - READ: fnt1/fnt2 hold latched rs1/rs2. dado_l_1/2 are captured at the end of READ.
//  - EXEC: op applied to captured operands and registered into dado at the end of EXEC.
//    ADD/SUB wrap modulo 2^DATA_W (SUB is two's complement). No carry or overflow output.
//  - WRITE: e_l=1, reg_e=rd, dado=value; reg_bank writes on the edge ending WRITE.
//    done=1 in the same cycle. result and zero update on that edge and hold until the
//    next done.
//  - e_l and done are 1 only in WRITE. Exactly one write per command.
//  - Latency, counted from the accept edge E0:
//      ALU op: e_l/done high in cycle 3; bank updated at E3; next accept at E4 earliest.
//      MOVI: e_l/done high in cycle 1; next accept at E2 earliest.
//  - RAW: the write completes before the next command's READ, so back-to-back dependent
//    commands read the new value. No bypass needed.
//  - fnt1/fnt2/reg_e hold their last values outside READ/WRITE.
//  - rs1==rs2 and rd==rs1/rs2 are legal: rd is read before it is written.
//  - Reset mid-command: e_l drops to 0 asynchronously and the command is discarded.
//    No done, and the target register is not modified.
//  - cmd_valid asserted while busy: held off, no effect.
// TESTING
//  1. Assert rst_n=0 mid-cycle -> all outputs 0 immediately; release -> cmd_ready=1,
//     busy=0.
//  2. MOVI r0,256 -> cycle 1: e_l=1, reg_e=00, dado=256, done=1. Then ADD r1=r0+r0 ->
//     READ fnt1=fnt2=00; cycle 3: e_l=1, reg_e=01, dado=512.
//  3. SUB r2=r0-r1 (256-512) -> dado=0xFFFFFF00, zero=0. SUB r3=r0-r0 -> dado=0,
//     zero=1. AND r2=r0&r1 -> 0, zero=1.
//  4. cmd_valid held high: MOVI r1,128 then ADD r2=r1+r1 -> accepts at E0 and E2;
//     r2=256 (no stale read); done pulses at cycles 1 and 5.
//  5. ADD r3=r0+r0 with rst_n pulsed low during EXEC -> e_l never 1, no done;
//     bank r3 unchanged (check via fnt read).
//  6. Change cmd_op/cmd_rd while busy -> ignored; the retired write uses the latched
//     values only.

Source files
------------

// File: rtl/reg_bank_seq_if.sv
// reg_bank_seq_if: command handshake plus reg_bank read/write bus for reg_bank_seq.
interface reg_bank_seq_if #(parameter int DATA_W = 32, parameter int ADDR_W = 2);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;
  logic              e_l;
  logic [ADDR_W-1:0] reg_e;
  logic [DATA_W-1:0] dado;
  logic [ADDR_W-1:0] fnt1;
  logic [ADDR_W-1:0] fnt2;
  logic [DATA_W-1:0] dado_l_1;
  logic [DATA_W-1:0] dado_l_2;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              done;
  logic              busy;
  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, dado_l_1, dado_l_2,
    input  cmd_ready, e_l, reg_e, dado, fnt1, fnt2, result, zero, done, busy
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, dado_l_1, dado_l_2,
    output cmd_ready, e_l, reg_e, dado, fnt1, fnt2, result, zero, done, busy
  );
endinterface

// File: rtl/reg_bank_seq.sv
// reg_bank_seq: sequences one ADD/SUB/AND/MOVI command at a time against reg_bank
// (read operands, execute, write back), one register write per command.
module reg_bank_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_bank_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MOVI = 2'd3;
  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d, fnt1_q, fnt1_d, fnt2_q, fnt2_d, reg_e_q, reg_e_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, dado_q, dado_d, result_q, result_d;
  logic              zero_q, zero_d;
  logic              accept;
  always_comb begin
    accept   = bus.cmd_valid && bus.cmd_ready;
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    fnt1_d   = fnt1_q;
    fnt2_d   = fnt2_q;
    reg_e_d  = reg_e_q;
    a_d      = a_q;
    b_d      = b_q;
    dado_d   = dado_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d = bus.cmd_op;
        rd_d = bus.cmd_rd;
        if (bus.cmd_op == OP_MOVI) begin
          state_d = WRITE;
          reg_e_d = bus.cmd_rd;
          dado_d  = bus.cmd_imm;
        end else begin
          state_d = READ;
          fnt1_d  = bus.cmd_rs1;
          fnt2_d  = bus.cmd_rs2;
        end
      end
      READ: begin
        a_d     = bus.dado_l_1;
        b_d     = bus.dado_l_2;
        state_d = EXEC;
      end
      EXEC: begin
        dado_d  = op_q == OP_ADD ? a_q + b_q : op_q == OP_SUB ? a_q - b_q : a_q & b_q;
        reg_e_d = rd_q;
        state_d = WRITE;
      end
      WRITE: begin
        result_d = dado_q;
        zero_d   = dado_q == '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      fnt1_q   <= '0;
      fnt2_q   <= '0;
      reg_e_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dado_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      fnt1_q   <= fnt1_d;
      fnt2_q   <= fnt2_d;
      reg_e_q  <= reg_e_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dado_q   <= dado_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end
  // rst_n gates ready directly so no accept can be seen while reset is held
  assign bus.cmd_ready = (state_q == IDLE) && rst_n;
  assign bus.e_l       = state_q == WRITE;
  assign bus.done      = state_q == WRITE;
  assign bus.busy      = state_q != IDLE;
  assign bus.reg_e     = reg_e_q;
  assign bus.dado      = dado_q;
  assign bus.fnt1      = fnt1_q;
  assign bus.fnt2      = fnt2_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_reg_bank_seq.sv
// tb_reg_bank_seq: drives reg_bank_seq against a behavioural 4-entry register bank and
// checks each retired command against an arithmetic model of the register contents.
module tb_reg_bank_seq;
  localparam int DW = 32, AW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_n = 0, total_n = 0, el_cnt = 0;
  logic [DW-1:0] bank [4];
  logic [DW-1:0] exp_bank [4];
  always #5 clk = ~clk;
  reg_bank_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_bank_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.dado_l_1 = bank[bus.fnt1];
  assign bus.dado_l_2 = bank[bus.fnt2];
  always @(posedge clk) begin
    if (bus.e_l) begin
      bank[bus.reg_e] <= bus.dado;
      el_cnt <= el_cnt + 1;
    end
  end

  function automatic logic [DW-1:0] alu(input logic [1:0] op, input logic [DW-1:0] a, b, imm);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return imm;
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [1:0] rd, rs1, rs2, input logic [DW-1:0] imm);
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
  endtask

  // Issues one command and observes it; comparisons are done by the calling test.
  task automatic exec_cmd(input logic [1:0] op, input logic [1:0] rd, rs1, rs2, input logic [DW-1:0] imm,
                          output int lat, output logic [1:0] f1, f2, re, output logic [DW-1:0] d, output logic el);
    @(negedge clk);
    drive(op, rd, rs1, rs2, imm);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    lat = -1; f1 = 'x; f2 = 'x; re = 'x; d = 'x; el = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin f1 = bus.fnt1; f2 = bus.fnt2; end
      if (bus.done) begin lat = c; re = bus.reg_e; d = bus.dado; el = bus.e_l; break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 total_n++;
    if ({bus.e_l, bus.reg_e, bus.dado, bus.fnt1, bus.fnt2, bus.result, bus.zero, bus.done, bus.cmd_ready, bus.busy} !== '0)
      $display("FAIL reset_outputs: e_l=%b reg_e=%0d dado=%h fnt=%0d/%0d result=%h zero=%b done=%b ready=%b busy=%b, want all 0",
               bus.e_l, bus.reg_e, bus.dado, bus.fnt1, bus.fnt2, bus.result, bus.zero, bus.done, bus.cmd_ready, bus.busy);
    else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
    #1 total_n++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) $display("FAIL reset_release: ready=%b busy=%b, want 1 0", bus.cmd_ready, bus.busy);
    else pass_n++;
  endtask

  task automatic test_movi_add;
    int lat; logic [1:0] f1, f2, re; logic [DW-1:0] d; logic el;
    exec_cmd(2'd3, 2'd0, 2'd2, 2'd1, 32'd256, lat, f1, f2, re, d, el);
    exp_bank[0] = 32'd256;
    total_n++;
    if (lat !== 1 || el !== 1'b1 || re !== 2'd0 || d !== 32'd256)
      $display("FAIL movi_r0: lat=%0d e_l=%b reg_e=%0d dado=%h, want 1 1 0 00000100", lat, el, re, d);
    else pass_n++;
    total_n++;
    if (bus.result !== 32'd256 || bank[0] !== 32'd256) $display("FAIL movi_result: result=%h bank0=%h, want 00000100", bus.result, bank[0]);
    else pass_n++;
    exec_cmd(2'd0, 2'd1, 2'd0, 2'd0, 32'd0, lat, f1, f2, re, d, el);
    exp_bank[1] = alu(2'd0, exp_bank[0], exp_bank[0], 0);
    total_n++;
    if (f1 !== 2'd0 || f2 !== 2'd0) $display("FAIL add_read_sel: fnt1=%0d fnt2=%0d, want 0 0", f1, f2);
    else pass_n++;
    total_n++;
    if (lat !== 3 || re !== 2'd1 || d !== 32'd512) $display("FAIL add_r1: lat=%0d reg_e=%0d dado=%h, want 3 1 00000200", lat, re, d);
    else pass_n++;
  endtask

  task automatic test_sub_and;
    int lat; logic [1:0] f1, f2, re; logic [DW-1:0] d, e; logic el;
    logic [1:0] ops [3] = '{2'd1, 2'd1, 2'd2};
    logic [1:0] rds [3] = '{2'd2, 2'd3, 2'd2};
    logic [1:0] r2s [3] = '{2'd1, 2'd0, 2'd1};
    logic [DW-1:0] want [3] = '{32'hFFFF_FF00, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      e = alu(ops[i], exp_bank[0], exp_bank[r2s[i]], 0);
      exp_bank[rds[i]] = e;
      exec_cmd(ops[i], rds[i], 2'd0, r2s[i], $urandom, lat, f1, f2, re, d, el);
      total_n++;
      if (lat !== 3 || re !== rds[i] || d !== want[i] || e !== want[i])
        $display("FAIL subandcase%0d: lat=%0d reg_e=%0d dado=%h, want 3 %0d %h", i, lat, re, d, rds[i], want[i]);
      else pass_n++;
      total_n++;
      if (bus.result !== want[i] || bus.zero !== (want[i] == 0))
        $display("FAIL subandflag%0d: result=%h zero=%b, want %h %b", i, bus.result, bus.zero, want[i], want[i] == 0);
      else pass_n++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] p = '0;
    @(negedge clk);
    drive(2'd3, 2'd1, 2'd0, 2'd0, 32'd128);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 drive(2'd0, 2'd2, 2'd1, 2'd1, 32'd0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      p[c] = bus.done;
      if (c == 2) begin
        total_n++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready: cmd_ready=%b in cycle 2, want 1", bus.cmd_ready);
        else pass_n++;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
      end
    end
    exp_bank[1] = 32'd128;
    exp_bank[2] = alu(2'd0, exp_bank[1], exp_bank[1], 0);
    total_n++;
    if (p !== 8'b0010_0010) $display("FAIL b2b_done: pulses=%b, want 00100010", p);
    else pass_n++;
    total_n++;
    if (bank[1] !== exp_bank[1] || bank[2] !== exp_bank[2]) $display("FAIL b2b_bank: r1=%h r2=%h, want %h %h", bank[1], bank[2], exp_bank[1], exp_bank[2]);
    else pass_n++;
  endtask

  task automatic test_reset_mid;
    int n0 = el_cnt;
    @(negedge clk);
    drive(2'd0, 2'd3, 2'd0, 2'd0, 32'd0);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 total_n++;
    if ({bus.e_l, bus.done, bus.busy, bus.cmd_ready, bus.dado} !== '0)
      $display("FAIL midrst_async: e_l=%b done=%b busy=%b ready=%b dado=%h, want all 0", bus.e_l, bus.done, bus.busy, bus.cmd_ready, bus.dado);
    else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total_n++;
    if (el_cnt !== n0 || bank[3] !== exp_bank[3] || bus.busy !== 1'b0)
      $display("FAIL midrst_discard: writes=%0d r3=%h busy=%b, want 0 %h 0", el_cnt - n0, bank[3], bus.busy, exp_bank[3]);
    else pass_n++;
  endtask

  task automatic test_hold_off;
    int lat = -1; logic [1:0] re; logic [DW-1:0] d, e; logic rdy = 1'b0;
    e = alu(2'd0, exp_bank[0], exp_bank[2], 0);
    @(negedge clk);
    drive(2'd0, 2'd1, 2'd0, 2'd2, 32'd0);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 drive(2'd3, 2'd3, 2'd1, 2'd1, $urandom);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rdy = rdy | bus.cmd_ready;
      if (bus.done) begin lat = c; re = bus.reg_e; d = bus.dado; break; end
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1 exp_bank[1] = e;
    total_n++;
    if (lat !== 3 || re !== 2'd1 || d !== e || rdy !== 1'b0)
      $display("FAIL holdoff_latched: lat=%0d reg_e=%0d dado=%h ready_seen=%b, want 3 1 %h 0", lat, re, d, rdy, e);
    else pass_n++;
    total_n++;
    if (bank[3] !== exp_bank[3] || bank[1] !== exp_bank[1] || bus.busy !== 1'b0)
      $display("FAIL holdoff_bank: r1=%h r3=%h busy=%b, want %h %h 0", bank[1], bank[3], bus.busy, exp_bank[1], exp_bank[3]);
    else pass_n++;
  endtask

  task automatic test_random;
    int lat; logic [1:0] op, rd, rs1, rs2, f1, f2, re; logic [DW-1:0] imm, d, e; logic el;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
      imm = (i % 5 == 0) ? 32'd0 : $urandom;
      e = alu(op, exp_bank[rs1], exp_bank[rs2], imm);
      exp_bank[rd] = e;
      exec_cmd(op, rd, rs1, rs2, imm, lat, f1, f2, re, d, el);
      total_n++;
      if (lat !== (op == 2'd3 ? 1 : 3) || el !== 1'b1 || re !== rd || d !== e)
        $display("FAIL rand%0d_write: op=%0d lat=%0d e_l=%b reg_e=%0d dado=%h, want lat %0d reg_e %0d dado %h",
                 i, op, lat, el, re, d, op == 2'd3 ? 1 : 3, rd, e);
      else pass_n++;
      total_n++;
      if (bank[rd] !== e || bus.result !== e || bus.zero !== (e == 0))
        $display("FAIL rand%0d_state: bank=%h result=%h zero=%b, want %h %b", i, bank[rd], bus.result, bus.zero, e, e == 0);
      else pass_n++;
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    drive(2'd0, 2'd0, 2'd0, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      bank[i] = $urandom;
      exp_bank[i] = bank[i];
    end
    test_reset;
    test_movi_add;
    test_sub_and;
    test_reset;
    test_back_to_back;
    test_reset_mid;
    test_hold_off;
    test_random;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
